// File: rtl/cpu_memory_stage_wait_if.sv
// Load/store IO bus between the memory stage (master) and the bus fabric (slave).
interface cpu_memory_stage_wait_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_BITS = 8
);
    logic [ADDR_BITS-1:0] addr;
    logic [WIDTH-1:0]     wrdata;
    logic                 rd;
    logic                 wr;
    logic                 ack;
    logic [WIDTH-1:0]     rddata;

    modport master (output addr, wrdata, rd, wr, input ack, rddata);
    modport slave  (input addr, wrdata, rd, wr, output ack, rddata);
endinterface

// File: rtl/cpu_memory_stage_wait.sv
// Stage 3 -> 4: branch resolution, stack-push select and a wait-state bus access
// with upstream stall and timeout.
module cpu_memory_stage_wait #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_BITS  = 3,
    parameter int unsigned IMM_BITS  = 16,
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned INT_TAG   = 0,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_3a,
    output logic                      stall_3a,
    input  logic [1:0]                c_branch_3a,
    input  logic [2:0]                c_push_3a,
    input  logic [1:0]                c_mem_3a,
    input  logic                      alu_cond_3a,
    input  logic [WIDTH-1:0]          alu_out_3a,
    input  logic [IMM_BITS-1:0]       imm_3a,
    input  logic [WIDTH+TAG_BITS-1:0] pushimm_3a,
    input  logic [WIDTH-1:0]          pc_3a,
    input  logic [WIDTH+TAG_BITS-1:0] r0_3a,
    input  logic [WIDTH+TAG_BITS-1:0] r1_3a,
    cpu_memory_stage_wait_if.master   bus,
    output logic                      valid_4a,
    output logic                      kill_4a,
    output logic [WIDTH-1:0]          branch_target_4a,
    output logic [2:0]                c_push_4a,
    output logic [WIDTH+TAG_BITS-1:0] st_push_4a,
    output logic [WIDTH-1:0]          pc_4a,
    output logic                      bus_err_4a
);
    localparam int unsigned CNT_BITS = $clog2(TIMEOUT + 1);
    localparam logic [TAG_BITS-1:0] TAG = TAG_BITS'(INT_TAG);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                    state_q, state_d;
    logic [CNT_BITS-1:0]       cnt_q, cnt_d;
    logic                      mem_op, strobe, stall, timeout;
    logic                      take_branch;
    logic [WIDTH-1:0]          rel_target, br_target;
    logic                      push_en;
    logic [WIDTH+TAG_BITS-1:0] push_word;
    logic [2:0]                c_push_next;

    logic                      valid_q, kill_q, bus_err_q;
    logic [WIDTH-1:0]          target_q, pc_q;
    logic [2:0]                c_push_q;
    logic [WIDTH+TAG_BITS-1:0] push_q;

    // Bus handshake FSM: strobe, stall and wait-state counter.
    always_comb begin
        mem_op  = in_valid_3a && (c_mem_3a == 2'd1 || c_mem_3a == 2'd2);
        state_d = state_q;
        cnt_d   = cnt_q;
        strobe  = 1'b0;
        stall   = 1'b0;
        timeout = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    strobe = 1'b1;
                    if (!bus.ack) begin
                        stall   = 1'b1;
                        state_d = StWait;
                        cnt_d   = CNT_BITS'(1);
                    end
                end
            end
            StWait: begin
                // Upstream holds its inputs while stalled, so c_mem_3a still names the op.
                strobe = 1'b1;
                if (bus.ack) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_BITS'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
        endcase
    end

    // Strobes and stall are forced low during reset, even mid-transaction.
    always_comb begin
        bus.addr   = alu_out_3a[ADDR_BITS-1:0];
        bus.wrdata = r1_3a[WIDTH-1:0];
        bus.rd     = !rst && strobe && (c_mem_3a == 2'd1);
        bus.wr     = !rst && strobe && (c_mem_3a == 2'd2);
        stall_3a   = !rst && stall;
    end

    // Branch decode and target computation (relative target wraps modulo 2^WIDTH).
    always_comb begin
        rel_target  = pc_3a + {{(WIDTH - IMM_BITS){imm_3a[IMM_BITS-1]}}, imm_3a};
        take_branch = 1'b0;
        br_target   = rel_target;
        case (c_branch_3a)
            2'd1: take_branch = 1'b1;
            2'd2: begin
                take_branch = 1'b1;
                br_target   = alu_out_3a;
            end
            2'd3: take_branch = alu_cond_3a;
            default: take_branch = 1'b0;
        endcase
    end

    // Push word select; a timed-out load pushes zero data and a null push code.
    always_comb begin
        push_en   = 1'b1;
        push_word = push_q;
        case (c_push_3a)
            3'd1: push_word = {TAG, alu_out_3a};
            3'd2: push_word = pushimm_3a;
            3'd3: push_word = r0_3a;
            3'd4: push_word = r1_3a;
            3'd5: push_word = timeout ? {TAG, {WIDTH{1'b0}}} : {TAG, bus.rddata};
            default: push_en = 1'b0;
        endcase
        c_push_next = (timeout && c_push_3a == 3'd5) ? 3'd0 : c_push_3a;
    end

    // State and stage-4 registers; results advance only on a non-stalled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            kill_q    <= 1'b0;
            bus_err_q <= 1'b0;
            target_q  <= '0;
            pc_q      <= '0;
            c_push_q  <= '0;
            push_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!stall) begin
                valid_q   <= in_valid_3a;
                kill_q    <= in_valid_3a && take_branch;
                bus_err_q <= in_valid_3a && timeout;
                c_push_q  <= c_push_next;
                if (in_valid_3a) begin
                    pc_q <= pc_3a;
                    if (take_branch) target_q <= br_target;
                    if (push_en)     push_q   <= push_word;
                end
            end else begin
                valid_q   <= 1'b0;
                kill_q    <= 1'b0;
                bus_err_q <= 1'b0;
            end
        end
    end

    assign valid_4a         = valid_q;
    assign kill_4a          = kill_q;
    assign bus_err_4a       = bus_err_q;
    assign branch_target_4a = target_q;
    assign pc_4a            = pc_q;
    assign c_push_4a        = c_push_q;
    assign st_push_4a       = push_q;
endmodule

// File: doc/cpu_memory_stage_wait.md
Name: cpu_memory_stage_wait

Overview:
Parametrised successor to the CPU memory/branch-resolution pipeline stage (stage 3 to stage 4). It resolves branches and selects the stack-push value, as before. It adds a real load/store bus transaction with a wait-state handshake, an upstream stall, and a bus timeout with an error flag. It sits between the ALU stage and the stack write-back stage, and drives the IO bus directly.

Parameters:
WIDTH, 32, datapath / PC width
TAG_BITS, 3, type-tag width on stack words
IMM_BITS, 16, branch offset width (sign-extended to WIDTH)
ADDR_BITS, 8, bus address width
INT_TAG, 0, tag value applied to ALU and load pushes
TIMEOUT, 16, max bus cycles before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid_3a  in  1  stage-3 instruction valid
stall_3a  out  1  hold stage 3 inputs (combinational)
c_branch_3a  in  2  0=NONE, 1=REL, 2=ALU, 3=REL_COND
c_push_3a  in  3  0=none, 1=ALU, 2=IMM, 3=REG0, 4=REG1, 5=LOAD, 6-7=none
c_mem_3a  in  2  0=none, 1=read, 2=write, 3=none
alu_cond_3a  in  1  branch condition
alu_out_3a  in  WIDTH  ALU result / bus address
imm_3a  in  IMM_BITS  branch offset
pushimm_3a  in  WIDTH+TAG_BITS  immediate push word
pc_3a  in  WIDTH  instruction PC
r0_3a, r1_3a  in  WIDTH+TAG_BITS  operand registers
bus_addr  out  ADDR_BITS  alu_out_3a[ADDR_BITS-1:0]
bus_wrdata  out  WIDTH  r1_3a[WIDTH-1:0]
bus_rd, bus_wr  out  1  bus strobes
bus_ack  in  1  transaction complete
bus_rddata  in  WIDTH  read data, valid with bus_ack
valid_4a  out  1  stage-4 result valid
kill_4a  out  1  flush younger stages
branch_target_4a  out  WIDTH  redirect PC
c_push_4a  out  3  registered push code
st_push_4a  out  WIDTH+TAG_BITS  word to push
pc_4a  out  WIDTH  passed-through PC
bus_err_4a  out  1  access timed out

Behaviour:
- Reset (async, immediate): state=IDLE, counter=0. All registered outputs are 0; bus_rd, bus_wr and stall_3a are 0 immediately, even mid-WAIT.
- States: IDLE, WAIT.
  - IDLE: a memory op is in_valid_3a && c_mem_3a in {1,2}.
  - Memory op: bus_rd/bus_wr asserted combinationally. If bus_ack is high in the same cycle, the op completes with zero stall. Otherwise go to WAIT with stall_3a=1 and counter=1.
  - WAIT: strobe held asserted and stall_3a=1. Upstream holds all inputs stable.
    - bus_ack: complete; stall_3a=0 in that cycle; go to IDLE.
    - No ack while counter==TIMEOUT-1: complete with error; strobe still asserted that cycle; go to IDLE.
    - Otherwise counter+1.
- Completion / non-memory instruction: registers update at the clock edge where stall_3a=0.
  - valid_4a=in_valid_3a.
  - When in_valid_3a=0: valid_4a=0 and kill_4a=0; st_push_4a, pc_4a and branch_target_4a hold.
- Branch:
  - kill_4a = valid && (BR in {REL, ALU} || (REL_COND && alu_cond_3a)).
  - branch_target_4a = pc_3a + sext(imm_3a) for REL/REL_COND, modulo 2^WIDTH. For ALU it is alu_out_3a.
  - Target updates only when kill_4a is set; otherwise it holds.
  - A branch combined with a memory op resolves only at bus completion.
- Push select:
  - ALU: {INT_TAG, alu_out_3a}.
  - IMM: pushimm_3a.
  - REG0/REG1: r0_3a / r1_3a.
  - LOAD: {INT_TAG, bus_rddata}, or {INT_TAG, 0} on timeout.
  - none (0, 6, 7): st_push_4a holds.
- c_push_4a <= c_push_3a, except timeout with push=LOAD gives c_push_4a=0.
- pc_4a <= pc_3a.
- bus_err_4a=1 for exactly one cycle on a timed-out completion, else 0.
- bus_ack in IDLE with no strobe is ignored.
- A write with c_push=LOAD pushes bus_rddata sampled at ack (documented as undefined use).

Test Plan:
- Reset mid-WAIT: read stalled 3 cycles, assert rst -> bus_rd and stall_3a drop the same cycle; all outputs 0; state IDLE after release.
- Zero-wait read: alu_out=0x12, c_push=LOAD, bus_ack same cycle with rddata=0xDEADBEEF -> stall_3a never 1; next cycle valid_4a=1 and st_push_4a={0,0xDEADBEEF}.
- 3-wait write: r1=0x55, ack on 4th cycle -> bus_wr high 4 cycles, bus_wrdata=0x55 throughout, stall_3a high 3 cycles, valid_4a pulses once.
- Timeout: read, no ack, TIMEOUT=16 -> strobe high 16 cycles; then bus_err_4a=1 and valid_4a=1 for one cycle, c_push_4a=0; next op proceeds normally.
- REL branch with wrap: pc=0xFFFFFFF0, imm=0x0020 -> kill_4a=1, target 0x00000010. REL_COND with cond=0 -> kill_4a=0 and target holds.
- Back-to-back bubble: valid ALU push 7, then in_valid=0 -> second cycle valid_4a=0, kill_4a=0, st_push_4a stays {0,7}.
